// File: rtl/jk_bank_sequencer_pkg.sv
// Shared constants, opcodes, FSM states and the J/K drive payload
// for the JK flip-flop bank sequencer.
package jk_bank_sequencer_pkg;

    localparam int unsigned BANK_W = 4;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_CLEAR  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SET    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_TOGGLE = OP_W'(4);
    localparam logic [OP_W-1:0] OP_INC    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_DEC    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHL    = OP_W'(7);

    localparam logic [BANK_W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

    typedef struct packed {
        logic [BANK_W-1:0] j;
        logic [BANK_W-1:0] k;
        logic [BANK_W-1:0] want;
    } drive_t;

    // Bit i toggles when every lower bit of 'bits' is set (ripple-carry mask).
    function automatic logic [BANK_W-1:0] carry_mask(input logic [BANK_W-1:0] bits);
        logic [BANK_W-1:0] t;
        t[0] = 1'b1;
        for (int unsigned i = 1; i < BANK_W; i++) begin
            t[i] = t[i-1] & bits[i-1];
        end
        return t;
    endfunction

endpackage

// File: rtl/jk_drive_calc.sv
// Combinational translation of an opcode plus current bank Q into J/K
// vectors and the Q value expected after one bank tick.
module jk_drive_calc
    import jk_bank_sequencer_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [BANK_W-1:0] din,
    input  logic              sin,
    input  logic [BANK_W-1:0] q,
    output drive_t            drive_c
);

    logic [BANK_W-1:0] inc_mask;
    logic [BANK_W-1:0] dec_mask;
    logic [BANK_W-1:0] shl_tgt;

    assign inc_mask = carry_mask(q);
    assign dec_mask = carry_mask(~q);
    assign shl_tgt  = {q[BANK_W-2:0], sin};

    always_comb begin
        drive_c = '0;
        case (op)
            OP_LOAD: begin
                drive_c.j    = din;
                drive_c.k    = ~din;
                drive_c.want = din;
            end
            OP_CLEAR: begin
                drive_c.k    = ALL_ONES;
                drive_c.want = '0;
            end
            OP_SET: begin
                drive_c.j    = ALL_ONES;
                drive_c.want = ALL_ONES;
            end
            OP_TOGGLE: begin
                drive_c.j    = ALL_ONES;
                drive_c.k    = ALL_ONES;
                drive_c.want = ~q;
            end
            OP_INC: begin
                drive_c.j    = inc_mask;
                drive_c.k    = inc_mask;
                drive_c.want = q + BANK_W'(1);
            end
            OP_DEC: begin
                drive_c.j    = dec_mask;
                drive_c.k    = dec_mask;
                drive_c.want = q - BANK_W'(1);
            end
            OP_SHL: begin
                drive_c.j    = shl_tgt;
                drive_c.k    = ~shl_tgt;
                drive_c.want = shl_tgt;
            end
            default: begin
                drive_c.want = q;
            end
        endcase
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequences one JK-bank operation per request: drive J/K, issue a single
// slot-aligned TICK, then verify the bank's Q and report DONE/ERR.
module jk_bank_sequencer
    import jk_bank_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 200000,
    parameter int unsigned SETTLE   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic [OP_W-1:0]   OP,
    input  logic [BANK_W-1:0] DIN,
    input  logic              SIN,
    input  logic [BANK_W-1:0] Q_FB,
    output logic [BANK_W-1:0] J,
    output logic [BANK_W-1:0] K,
    output logic              TICK,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    state_t            state_q;
    state_t            state_d;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [SET_W-1:0]  settle_q;
    logic [SET_W-1:0]  settle_d;
    logic [BANK_W-1:0] want_q;
    logic [BANK_W-1:0] want_d;
    logic [BANK_W-1:0] j_d;
    logic [BANK_W-1:0] k_d;
    logic              tick_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic              slot_next;
    drive_t            calc;

    jk_drive_calc u_calc (
        .op      (OP),
        .din     (DIN),
        .sin     (SIN),
        .q       (Q_FB),
        .drive_c (calc)
    );

    // Free-running slot divider; TICK is registered, so look one count ahead.
    assign div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    assign slot_next = (div_d == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        want_d   = want_q;
        j_d      = J;
        k_d      = K;
        tick_d   = 1'b0;
        busy_d   = BUSY;
        done_d   = 1'b0;
        err_d    = ERR;
        case (state_q)
            ST_IDLE: begin
                j_d = '0;
                k_d = '0;
                if (REQ) begin
                    state_d = ST_APPLY;
                    j_d     = calc.j;
                    k_d     = calc.k;
                    want_d  = calc.want;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    tick_d  = slot_next;
                end
            end
            ST_APPLY: begin
                if (TICK) begin
                    state_d  = ST_VERIFY;
                    j_d      = '0;
                    k_d      = '0;
                    settle_d = '0;
                end else begin
                    tick_d = slot_next;
                end
            end
            ST_VERIFY: begin
                if (settle_q == SET_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (Q_FB != want_q) begin
                        err_d = 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                j_d     = '0;
                k_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            settle_q <= '0;
            want_q   <= '0;
            J        <= '0;
            K        <= '0;
            TICK     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            settle_q <= settle_d;
            want_q   <= want_d;
            J        <= j_d;
            K        <= k_d;
            TICK     <= tick_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
            ERR      <= err_d;
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench: behavioural JK bank driven by TICK, an arithmetic
// reference model for J/K/target and slot timing, table plus random ops.
module tb_jk_bank_sequencer;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned SETTLE   = 1;

    logic       CLK;
    logic       RST;
    logic       REQ;
    logic [2:0] OP;
    logic [3:0] DIN;
    logic       SIN;
    logic [3:0] Q_FB;
    logic [3:0] J;
    logic [3:0] K;
    logic       TICK;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    logic [3:0] bank_q;
    logic       bank_ignore;
    int         model_cnt;
    int         checks;
    int         errors;

    jk_bank_sequencer #(.TICK_DIV(TICK_DIV), .SETTLE(SETTLE)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .OP   (OP),
        .DIN  (DIN),
        .SIN  (SIN),
        .Q_FB (Q_FB),
        .J    (J),
        .K    (K),
        .TICK (TICK),
        .BUSY (BUSY),
        .DONE (DONE),
        .ERR  (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign Q_FB = bank_q;

    // Behavioural JK bank, clocked by CLK and enabled by TICK.
    always @(posedge CLK) begin
        if (RST) begin
            bank_q <= 4'h0;
        end else if (TICK && !bank_ignore) begin
            for (int i = 0; i < 4; i++) begin
                case ({J[i], K[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    // Slot phase reference: cycles since reset release, modulo TICK_DIV.
    always @(posedge CLK) begin
        if (RST) model_cnt <= 0;
        else     model_cnt <= (model_cnt + 1) % TICK_DIV;
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] din;
        logic       sin;
        logic       ign;
        logic [3:0] want_q;
        logic       want_err;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_target(input logic [2:0] op, input logic [3:0] din,
                                                input logic sin, input logic [3:0] q);
        int v;
        case (op)
            3'd0:    v = int'(q);
            3'd1:    v = int'(din);
            3'd2:    v = 0;
            3'd3:    v = 15;
            3'd4:    v = 15 - int'(q);
            3'd5:    v = (int'(q) + 1) % 16;
            3'd6:    v = (int'(q) + 15) % 16;
            default: v = (int'(q) * 2 + int'(sin)) % 16;
        endcase
        return 4'(v);
    endfunction

    // Toggle-style ops drive exactly the changing bits; set/reset-style ops force the target.
    task automatic model_jk(input logic [2:0] op, input logic [3:0] q, input logic [3:0] tgt,
                            output logic [3:0] j, output logic [3:0] k);
        if (op == 3'd0 || op == 3'd4 || op == 3'd5 || op == 3'd6) begin
            j = q ^ tgt;
            k = q ^ tgt;
        end else begin
            j = tgt;
            k = ~tgt;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [3:0] din, input logic sin,
                          input logic ign, input logic poke,
                          input logic [3:0] want_q, input logic want_err);
        logic [3:0] q0, tgt, ej, ek;
        int p, ew, w, d, ticks;
        bit stable, quiet;
        q0  = bank_q;
        tgt = model_target(op, din, sin, q0);
        model_jk(op, q0, tgt, ej, ek);
        p  = model_cnt;
        ew = (TICK_DIV - 1) - p;
        if (ew == 0) ew = TICK_DIV;
        bank_ignore = ign;
        REQ = 1'b1; OP = op; DIN = din; SIN = sin;
        w = 0; d = 0; ticks = 0; stable = 1'b1; quiet = 1'b1;
        for (int i = 1; i <= 16 && d == 0; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                REQ = 1'b0;
                chk("accept_busy", BUSY, 1);
                chk("accept_err_clr", ERR, 0);
                chk("apply_j", J, ej);
                chk("apply_k", K, ek);
                if (poke) begin
                    REQ = 1'b1; OP = 3'd1; DIN = ~din;
                end
            end else if (i == 2) begin
                REQ = 1'b0;
            end
            if (w == 0 && (J !== ej || K !== ek)) stable = 1'b0;
            if (w != 0 && (J !== 4'h0 || K !== 4'h0)) quiet = 1'b0;
            if (TICK === 1'b1) begin
                ticks++;
                if (w == 0) w = i;
            end
            if (DONE === 1'b1) begin
                d = i;
                chk("done_busy_low", BUSY, 0);
                chk("done_err", ERR, want_err);
            end
        end
        REQ = 1'b0;
        if (d == 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("tick_phase", w, ew);
            chk("done_after_tick", d, w + SETTLE + 1);
            chk("tick_count", ticks, 1);
            chk("jk_stable", 32'(stable), 1);
            chk("jk_released", 32'(quiet), 1);
            chk("bank_q", bank_q, want_q);
            @(negedge CLK);
            chk("done_one_cycle", DONE, 0);
        end
        bank_ignore = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * TICK_DIV && model_cnt != p; i++) @(negedge CLK);
        chk("phase_reached", model_cnt, p);
    endtask

    initial begin
        int ticks;
        logic [2:0] rop;
        logic [3:0] rdin, rtgt;
        logic rsin;
        checks = 0; errors = 0;
        RST = 1'b1; REQ = 1'b0; OP = 3'd0; DIN = 4'h0; SIN = 1'b0; bank_ignore = 1'b0;

        tbl[0]  = '{3'd1, 4'hA, 1'b0, 1'b0, 4'hA, 1'b0};
        tbl[1]  = '{3'd3, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0};
        tbl[2]  = '{3'd5, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[3]  = '{3'd6, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0};
        tbl[4]  = '{3'd1, 4'h9, 1'b0, 1'b0, 4'h9, 1'b0};
        tbl[5]  = '{3'd7, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0};
        tbl[6]  = '{3'd2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[7]  = '{3'd4, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0};
        tbl[8]  = '{3'd0, 4'h5, 1'b0, 1'b0, 4'hF, 1'b0};
        tbl[9]  = '{3'd5, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[10] = '{3'd1, 4'h6, 1'b0, 1'b1, 4'h0, 1'b1};
        tbl[11] = '{3'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[12] = '{3'd7, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};

        repeat (3) begin
            @(negedge CLK);
            chk("reset_outputs", {J, K, TICK, BUSY, DONE, ERR}, 0);
        end
        RST = 1'b0;
        ticks = 0;
        repeat (20) begin
            @(negedge CLK);
            if (TICK === 1'b1) ticks++;
        end
        chk("idle_no_tick", ticks, 0);
        chk("idle_not_busy", BUSY, 0);

        for (int n = 0; n < 13; n++) begin
            run_op(tbl[n].op, tbl[n].din, tbl[n].sin, tbl[n].ign, 1'b0,
                   tbl[n].want_q, tbl[n].want_err);
            if (tbl[n].ign) begin
                repeat (5) begin
                    @(negedge CLK);
                    chk("err_sticky", ERR, 1);
                end
            end
        end

        // Second request during APPLY must be ignored.
        run_op(3'd5, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
        ticks = 0;
        repeat (6) begin
            @(negedge CLK);
            if (TICK === 1'b1) ticks++;
        end
        chk("poke_no_extra_tick", ticks, 0);
        chk("poke_idle_busy", BUSY, 0);

        // Reset inside APPLY before the slot aborts with no TICK.
        wait_phase(TICK_DIV - 1);
        REQ = 1'b1; OP = 3'd1; DIN = 4'h5;
        @(negedge CLK);
        REQ = 1'b0;
        chk("abort_busy", BUSY, 1);
        chk("abort_pre_tick", TICK, 0);
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("abort_reset_outputs", {J, K, TICK, BUSY, DONE, ERR}, 0);
        end
        RST = 1'b0;
        ticks = 0;
        repeat (10) begin
            @(negedge CLK);
            if (TICK === 1'b1) ticks++;
        end
        chk("abort_no_tick", ticks, 0);
        chk("abort_idle", BUSY, 0);

        // Latency sweep over every divider phase.
        for (int p = 0; p < TICK_DIV; p++) begin
            wait_phase(p);
            rtgt = model_target(3'd5, 4'h0, 1'b0, bank_q);
            run_op(3'd5, 4'h0, 1'b0, 1'b0, 1'b0, rtgt, 1'b0);
        end

        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            rop  = 3'($urandom_range(0, 7));
            rdin = 4'($urandom_range(0, 15));
            rsin = 1'($urandom_range(0, 1));
            rtgt = model_target(rop, rdin, rsin, bank_q);
            run_op(rop, rdin, rsin, 1'b0, 1'b0, rtgt, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
Command sequencer for a 4-bit JK flip-flop bank. It accepts one operation per request and translates it into J/K vectors using the bank's current Q. It then issues a single slow-rate clock-enable TICK to the bank, checks the bank's resulting Q against the expected value, and reports DONE/ERR. It sits between the switch/button front end and the JK bank; the bank is clocked by CLK and gated by TICK rather than by its own divided clock.

Parameters:
TICK_DIV, 200000, CLK cycles per tick slot; free-running divider period; must be >= 2.
SETTLE, 2, CLK cycles waited after TICK before sampling Q_FB; must be >= 1.

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
REQ  input  1  operation request, sampled only in IDLE
OP  input  3  opcode: 0 HOLD, 1 LOAD, 2 CLEAR, 3 SET, 4 TOGGLE, 5 INC, 6 DEC, 7 SHL
DIN  input  4  LOAD data
SIN  input  1  SHL serial-in bit
Q_FB  input  4  JK bank Q output
J  output  4  J vector to bank
K  output  4  K vector to bank
TICK  output  1  one-cycle bank clock enable
BUSY  output  1  high from request accept until DONE
DONE  output  1  one-cycle completion pulse
ERR  output  1  verify-mismatch flag, sticky

Behaviour:
- Reset: state IDLE, divider 0, J=K=0, TICK=0, BUSY=0, DONE=0, ERR=0. RST has priority over every event; RST during APPLY/VERIFY aborts the operation with no TICK issued afterwards.
- Divider:
  - Counter 0..TICK_DIV-1, free-running; width $clog2(TICK_DIV).
  - slot = (count == TICK_DIV-1).
- FSM IDLE:
  - REQ=1 latches OP/DIN/SIN.
  - Computes J/K and EXPECT from the current Q_FB and registers them.
  - Sets BUSY=1 and clears ERR. Next state is APPLY.
- J/K/EXPECT per op, where T = toggle mask:
  - HOLD: J=K=0, EXPECT=Q.
  - LOAD: J=DIN, K=~DIN, EXPECT=DIN.
  - CLEAR: J=0, K=F, EXPECT=0.
  - SET: J=F, K=0, EXPECT=F.
  - TOGGLE: J=K=F, EXPECT=~Q.
  - INC: T[i]=&Q[i-1:0] (T[0]=1), J=K=T, EXPECT=Q+1 mod 16.
  - DEC: T[i]=&~Q[i-1:0] (T[0]=1), J=K=T, EXPECT=Q-1 mod 16.
  - SHL: tgt={Q[2:0],SIN}, J=tgt, K=~tgt, EXPECT=tgt.
- FSM APPLY:
  - J/K are held stable.
  - On the first cycle with slot=1, TICK=1 for exactly that cycle; next state is VERIFY.
  - Wait in APPLY is 1..TICK_DIV cycles.
- FSM VERIFY:
  - J=K=0 on entry.
  - Waits SETTLE cycles, then compares Q_FB to EXPECT.
  - Mismatch sets ERR=1.
  - DONE=1 for one cycle and BUSY=0 in that same cycle; next state is IDLE.
- Outside APPLY: J=K=0 and TICK=0, so the bank holds.
- REQ while BUSY is ignored; no queueing. REQ held high re-triggers a new operation on the cycle after DONE.
- Exactly one TICK per accepted request.
- ERR holds until the next accepted REQ or RST.
- Total latency from REQ accept to DONE: 1 + (1..TICK_DIV) + SETTLE cycles.

Decomposition:
- Shared package holds:
  - opcode localparams OP_HOLD..OP_SHL;
  - FSM state encodings IDLE/APPLY/VERIFY;
  - bank width constant 4.
- One natural sub-module is jk_drive_calc. It is purely combinational: (OP, DIN, SIN, Q) -> (J, K, EXPECT). It is reusable by the bench's reference model.
- The divider stays inline.

Test Plan:
1. Reset check (bench uses TICK_DIV=4, SETTLE=1, behavioural JK bank gated by TICK): assert RST 3 cycles -> J=K=0, TICK=BUSY=DONE=ERR=0. Release with no REQ for 20 cycles -> TICK never asserts.
2. LOAD: REQ with OP=1, DIN=4'hA from Q=0 -> J=4'hA, K=4'h5 during APPLY, one TICK, Q_FB=4'hA, DONE pulse, ERR=0.
3. INC wrap: Q=4'hF, OP=5 -> J=K=4'hF, Q becomes 4'h0. Then DEC from 4'h0 -> Q becomes 4'hF. Then SHL with SIN=1 from 4'h9 -> Q becomes 4'h3.
4. Mismatch: bank model ignores TICK, LOAD 4'h6 with Q=0 -> DONE with ERR=1; ERR stays 1 over idle cycles. Next accepted REQ (HOLD) clears ERR, and its DONE leaves ERR=0.
5. Busy/abort: second REQ during APPLY -> ignored, exactly one TICK observed. RST asserted in APPLY before slot -> no TICK, all outputs return to reset values.
6. Latency sweep: issue REQ at each of the 4 divider phases -> TICK cycle is 1..4 cycles after accept and DONE is exactly SETTLE+1 cycles after TICK.
